au_cmd_sequencer: RTL and testbench

//   Host-side initiator for the 16-bit arithmetic unit (AU) pin interface: drives ui_in/uio_in, reads uo_out/uio_out.

---
 rtl/au_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_au_cmd_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_cmd_sequencer.sv
// Host-side initiator for the 16-bit arithmetic unit pin interface: loads A/B bytewise,
// runs one ADD/SUB/MUL, reads B back and returns it with P/N/ERR on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// WR_S  | write strobe: REG=idx, RW=1, S=1, operand byte on data_out
// WR_G  | write gap: S low, fields held
// EX    | execute: OP/C/UA driven, S high for ADDSUB_CYC or MUL_CYC cycles
// EX_G  | ctrl all zero so the AU counter resets
// RD_S  | read select: REG=idx, RW=0, S=0
// RD_W  | wait READ_LAT cycles, then capture data_in as result byte idx
// RESP  | response held until rsp_ready
module au_cmd_sequencer #(
  parameter int ADDSUB_CYC = 16,
  parameter int MUL_CYC    = 128,
  parameter int READ_LAT   = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_c,
  input  logic        req_ua,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_x,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_p,
  output logic        rsp_n,
  output logic        rsp_err,
  output logic [7:0]  data_out,
  output logic [7:0]  ctrl_out,
  input  logic [7:0]  data_in,
  input  logic [7:0]  status_in
);

  localparam int EXEC_MAX = (MUL_CYC > ADDSUB_CYC) ? MUL_CYC : ADDSUB_CYC;
  localparam int CNT_MAX  = (EXEC_MAX > READ_LAT) ? EXEC_MAX : READ_LAT;
  localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] ADDSUB_LD = CW'(ADDSUB_CYC - 1);
  localparam logic [CW-1:0] MUL_LD    = CW'(MUL_CYC - 1);
  localparam logic [CW-1:0] RD_LD     = CW'(READ_LAT - 1);

  typedef enum logic [2:0] {IDLE, WR_S, WR_G, EX, EX_G, RD_S, RD_W, RESP} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic          c_q;
  logic          ua_q;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic [7:0]    x_q;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic          status_unused;

  assign status_unused = ^{status_in[7:5], status_in[2:1]};

  function automatic logic [7:0] reg_ctrl(input logic [1:0] i, input logic rw, input logic s);
    return {3'b000, i, rw, s, 1'b0};
  endfunction

  function automatic logic [7:0] wr_byte(input logic [1:0] i, input logic [15:0] a,
                                         input logic [15:0] b);
    case (i)
      2'd0:    return a[7:0];
      2'd1:    return a[15:8];
      2'd2:    return b[7:0];
      default: return b[15:8];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_p      <= 1'b0;
      rsp_n      <= 1'b0;
      rsp_err    <= 1'b0;
      data_out   <= '0;
      ctrl_out   <= '0;
      op_q       <= '0;
      c_q        <= 1'b0;
      ua_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      idx        <= '0;
      cnt        <= '0;
    end else begin
      // AU error is sticky for the whole transaction but frozen once the response is up
      if (state != IDLE && state != RESP && status_in[0])
        rsp_err <= 1'b1;

      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            c_q        <= req_c;
            ua_q       <= req_ua;
            a_q        <= req_a;
            b_q        <= req_b;
            x_q        <= req_x;
            rsp_result <= '0;
            rsp_p      <= 1'b0;
            rsp_n      <= 1'b0;
            req_ready  <= 1'b0;
            if (req_op == 2'b00) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rsp_err  <= 1'b0;
              idx      <= 2'd0;
              data_out <= req_a[7:0];
              ctrl_out <= reg_ctrl(2'd0, 1'b1, 1'b1);
              state    <= WR_S;
            end
          end
        end
        WR_S: begin
          ctrl_out[1] <= 1'b0;
          state       <= WR_G;
        end
        WR_G: begin
          if (idx != 2'd3) begin
            idx      <= idx + 2'd1;
            data_out <= wr_byte(idx + 2'd1, a_q, b_q);
            ctrl_out <= reg_ctrl(idx + 2'd1, 1'b1, 1'b1);
            state    <= WR_S;
          end else begin
            // UA has no meaning for MUL, so bit 2 is kept low there
            data_out <= x_q;
            ctrl_out <= {c_q, op_q, 2'b00, ua_q & (op_q != 2'b11), 1'b1, 1'b0};
            cnt      <= (op_q == 2'b11) ? MUL_LD : ADDSUB_LD;
            state    <= EX;
          end
        end
        EX: begin
          if (cnt == '0) begin
            rsp_p    <= status_in[4];
            rsp_n    <= status_in[3];
            ctrl_out <= '0;
            data_out <= '0;
            state    <= EX_G;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EX_G: begin
          idx      <= 2'd2;
          ctrl_out <= reg_ctrl(2'd2, 1'b0, 1'b0);
          state    <= RD_S;
        end
        RD_S: begin
          cnt   <= RD_LD;
          state <= RD_W;
        end
        RD_W: begin
          if (cnt == '0) begin
            if (idx == 2'd2) begin
              rsp_result[7:0] <= data_in;
              idx             <= 2'd3;
              ctrl_out        <= reg_ctrl(2'd3, 1'b0, 1'b0);
              state           <= RD_S;
            end else begin
              rsp_result[15:8] <= data_in;
              ctrl_out         <= '0;
              rsp_valid        <= 1'b1;
              state            <= RESP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_au_cmd_sequencer.sv
// Scoreboard bench for au_cmd_sequencer with a behavioural AU on the pin side.
module tb_au_cmd_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic        req_c, req_ua;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_x;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_p, rsp_n, rsp_err;
  logic [7:0]  data_out, ctrl_out;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  status_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  au_cmd_sequencer dut (
    .clk(clk), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_c(req_c),
    .req_ua(req_ua), .req_a(req_a), .req_b(req_b), .req_x(req_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_p(rsp_p), .rsp_n(rsp_n), .rsp_err(rsp_err),
    .data_out(data_out), .ctrl_out(ctrl_out), .data_in(data_in), .status_in(status_in)
  );

  // Behavioural AU: byte writes on S with OP=00/RW=1, whole op on the first S-high execute cycle
  logic [15:0] au_a = 16'h0, au_b = 16'h0;
  logic        au_p = 1'b0, au_n = 1'b0, au_prev_s = 1'b0;
  logic        inj_err = 1'b0;

  assign status_in = {3'b000, au_p, au_n, 1'b0, 1'b0, inj_err};

  function automatic logic [17:0] au_exec(input logic [1:0] op, input logic c, input logic ua,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] x);
    logic [15:0] xe, addend, res;
    logic [16:0] sum;
    logic [31:0] prod;
    logic        p;
    xe     = c ? {{8{x[7]}}, x} : {8'h00, x};
    addend = ua ? a : xe;
    p      = 1'b0;
    res    = 16'h0;
    case (op)
      2'b01: begin
        sum = {1'b0, b} + {1'b0, addend};
        res = sum[15:0];
        p   = c ? (b[15] == addend[15] && res[15] != b[15]) : sum[16];
      end
      2'b10: begin
        sum = {1'b0, b} - {1'b0, addend};
        res = sum[15:0];
        p   = c ? (b[15] != addend[15] && res[15] != b[15]) : sum[16];
      end
      default: begin
        prod = {16'h0, a} * {16'h0, xe};
        res  = b + prod[15:0];
      end
    endcase
    return {p, c & res[15], res};
  endfunction

  always @(posedge clk) begin
    au_prev_s <= ctrl_out[1];
    case (ctrl_out[4:3])
      2'd0:    data_in <= au_a[7:0];
      2'd1:    data_in <= au_a[15:8];
      2'd2:    data_in <= au_b[7:0];
      default: data_in <= au_b[15:8];
    endcase
    if (ctrl_out[1] && ctrl_out[6:5] == 2'b00 && ctrl_out[2]) begin
      case (ctrl_out[4:3])
        2'd0:    au_a[7:0]  <= data_out;
        2'd1:    au_a[15:8] <= data_out;
        2'd2:    au_b[7:0]  <= data_out;
        default: au_b[15:8] <= data_out;
      endcase
    end else if (ctrl_out[1] && ctrl_out[6:5] != 2'b00 && !au_prev_s) begin
      {au_p, au_n, au_b} <= au_exec(ctrl_out[6:5], ctrl_out[7], ctrl_out[2], au_a, au_b, data_out);
    end
  end

  typedef struct {
    logic [15:0] res;
    logic        p;
    logic        n;
    logic        err;
    int          lat;
    int          rises;
    int          run;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency from the first post-accept cycle, S pulse count, execute run length
  initial begin : monitor
    int   acc = 0, lat = 0, rises = 0, cur_run = 0, run = 0;
    logic seen_valid = 1'b1, prev_s = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (RST) begin
        seen_valid = 1'b1;
        rises      = 0;
        cur_run    = 0;
        run        = 0;
      end else begin
        if (req_valid && req_ready) begin
          acc        = cyc + 1;
          rises      = 0;
          run        = 0;
          cur_run    = 0;
          seen_valid = 1'b0;
        end
        if (ctrl_out[1] && !prev_s) rises++;
        if (ctrl_out[1] && ctrl_out[6:5] != 2'b00) begin
          if (ctrl_out[6:5] == 2'b11 && cur_run == 0) chk("mul_ua_bit", 32'(ctrl_out[2]), 0);
          cur_run++;
        end else if (cur_run != 0) begin
          run     = cur_run;
          cur_run = 0;
        end
        if (rsp_valid && !seen_valid) begin
          lat        = cyc - acc;
          seen_valid = 1'b1;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_p", 32'(rsp_p), 32'(e.p));
            chk("rsp_n", 32'(rsp_n), 32'(e.n));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(lat), 32'(e.lat));
            chk("s_pulses", 32'(rises), 32'(e.rises));
            chk("exec_run", 32'(run), 32'(e.run));
          end
        end
      end
      prev_s = ctrl_out[1];
    end
  end

  task automatic push_exp(input logic [15:0] res, input logic p, input logic n, input logic err,
                          input int lat, input int rises, input int run);
    exp_t e;
    e.res = res; e.p = p; e.n = n; e.err = err; e.lat = lat; e.rises = rises; e.run = run;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic c, input logic ua,
                           input logic [15:0] a, input logic [15:0] b, input logic [7:0] x);
    req_op = op; req_c = c; req_ua = ua; req_a = a; req_b = b; req_x = x;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept", 32'(got), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic ctrl_zero);
    logic got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ctrl_zero) chk("illegal_ctrl_zero", 32'({ctrl_out, data_out}), 0);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("rsp_handshake", 32'(got), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [18:0] snap;
    int          ex_cnt;
    RST = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_c = 1'b0; req_ua = 1'b0; req_a = '0; req_b = '0; req_x = '0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_fields", 32'({rsp_result, rsp_p, rsp_n, rsp_err}), 0);
    chk("rst_pins", 32'({data_out, ctrl_out}), 0);
    @(posedge clk); #1;

    // ADD unsigned, SUB signed, MUL, illegal op
    push_exp(16'h0008, 1'b0, 1'b0, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b0, 16'h0000, 16'h0005, 8'h03);
    wait_accept(); wait_rsp(1'b0);

    push_exp(16'hFFFD, 1'b0, 1'b1, 1'b0, 31, 5, 16);
    drive_req(2'b10, 1'b1, 1'b0, 16'h0000, 16'h0002, 8'h05);
    wait_accept(); wait_rsp(1'b0);

    push_exp(16'h002A, 1'b0, 1'b0, 1'b0, 143, 5, 128);
    drive_req(2'b11, 1'b0, 1'b1, 16'h0007, 16'h0000, 8'h06);
    wait_accept(); wait_rsp(1'b0);

    push_exp(16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    drive_req(2'b00, 1'b0, 1'b0, 16'h1111, 16'h2222, 8'h33);
    wait_accept(); wait_rsp(1'b1);

    // Backpressure: ADD using reg A as addend, then signed overflow queued behind it
    rsp_ready = 1'b0;
    push_exp(16'h1334, 1'b0, 1'b0, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b1, 16'h1234, 16'h0100, 8'h10);
    wait_accept();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("hold_rsp_valid", 32'(rsp_valid), 1);
    snap = {rsp_result, rsp_p, rsp_n, rsp_err};
    @(posedge clk); #1;
    push_exp(16'h8000, 1'b1, 1'b1, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b1, 1'b0, 16'h0000, 16'h7FFF, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable", 32'({rsp_valid, rsp_result, rsp_p, rsp_n, rsp_err}), 32'({1'b1, snap}));
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("handshake_no_reaccept", 32'(req_ready), 0);
    @(negedge clk);
    chk("reaccept_next_cycle", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_rsp(1'b0);

    // Reset in the fifth execute cycle aborts; the next ADD runs cleanly
    push_exp(16'h0000, 1'b0, 1'b0, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b0, 16'h0000, 16'h0040, 8'h04);
    wait_accept();
    ex_cnt = 0;
    for (int i = 0; i < 100 && ex_cnt < 5; i++) begin
      @(negedge clk);
      if (ctrl_out[1] && ctrl_out[6:5] != 2'b00) ex_cnt++;
    end
    chk("reached_ex5", 32'(ex_cnt), 5);
    RST = 1'b1;
    @(posedge clk); #1 RST = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 1);
    chk("abort_pins", 32'({ctrl_out, data_out}), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge clk); #1;
    push_exp(16'h0100, 1'b0, 1'b0, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b0, 16'h0000, 16'h00FF, 8'h01);
    wait_accept(); wait_rsp(1'b0);

    // One-cycle AU ERR pulse mid-transaction
    push_exp(16'h0030, 1'b0, 1'b0, 1'b1, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b0, 16'h0000, 16'h0010, 8'h20);
    wait_accept();
    repeat (3) @(posedge clk);
    #1 inj_err = 1'b1;
    @(posedge clk); #1 inj_err = 1'b0;
    wait_rsp(1'b0);

    // Error flag must not leak into a clean follow-up transaction
    push_exp(16'h0009, 1'b0, 1'b0, 1'b0, 31, 5, 16);
    drive_req(2'b01, 1'b0, 1'b0, 16'h0000, 16'h0004, 8'h05);
    wait_accept(); wait_rsp(1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
